// File: rtl/uart_tx_word_streamer.sv
// Word FIFO feeding a byte serializer for UART_TX. Optional line terminator
// after each word is compiled in with `define UART_TX_NEWLINE_EN.
//
// state | meaning
// IDLE  | no word in flight, waiting for the FIFO to hold a word
// SEND  | presenting data byte idx_q of the word in shift_q
// TERM  | presenting the 8'h0A terminator (only with UART_TX_NEWLINE_EN)
module uart_tx_word_streamer #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int MSB_FIRST  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    byte_data,
   output logic                          byte_valid,
   input  logic                          byte_ready,
   output logic                          word_done,
   output logic                          busy
);

   localparam int NB    = DATA_W / 8;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1
`ifdef UART_TX_NEWLINE_EN
      , TERM = 2'd2
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                word_done_q, word_done_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

   logic push, pop, xfer, finish;

   assign wr_full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign push       = wr_en && !wr_full;
   assign byte_valid = (state_q != IDLE);
   assign xfer       = byte_valid && byte_ready;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      pop         = 1'b0;
      finish      = 1'b0;
      word_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (idx_q == IDX_W'(NB - 1)) begin
`ifdef UART_TX_NEWLINE_EN
                  state_d = TERM;
`else
                  finish  = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
               end
            end
         end
`ifdef UART_TX_NEWLINE_EN
         TERM: begin
            if (xfer) finish = 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase

      // Finished word: reload straight from the FIFO so there is no bubble.
      if (finish) begin
         word_done_d = 1'b1;
         if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
            state_d = SEND;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      overflow_d = overflow_q | (wr_en & wr_full);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         idx_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         word_done_q <= word_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_comb begin
      byte_data = (MSB_FIRST != 0) ? shift_q[DATA_W-1 -: 8] : shift_q[7:0];
`ifdef UART_TX_NEWLINE_EN
      if (state_q == TERM) byte_data = 8'h0A;
`endif
   end

   assign overflow   = overflow_q;
   assign fifo_count = count_q;
   assign word_done  = word_done_q;
   assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_word_streamer.sv
// Directed bench for uart_tx_word_streamer: an MSB-first and an LSB-first
// instance, byte/word_done capture on the falling edge, immediate-assert checks.
module tb_uart_tx_word_streamer;

`ifdef UART_TX_NEWLINE_EN
   localparam int NL = 1;
`else
   localparam int NL = 0;
`endif
   localparam int BPW = 4 + NL;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0, wr_en_l = 1'b0;
   logic [31:0] wr_data = '0, wr_data_l = '0;
   logic        byte_ready = 1'b0, byte_ready_l = 1'b0;
   logic        wr_full, overflow, byte_valid, word_done, busy;
   logic        wr_full_l, overflow_l, byte_valid_l, word_done_l, busy_l;
   logic [2:0]  fifo_count, fifo_count_l;
   logic [7:0]  byte_data, byte_data_l;

   int n_checks = 0;
   int n_err    = 0;
   int done_cnt = 0, done_cnt_l = 0;
   logic [7:0] got[$], got_l[$], exp_q[$];

   always #5 clk = ~clk;

   uart_tx_word_streamer #(.DATA_W(32), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(wr_full), .overflow(overflow), .fifo_count(fifo_count),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .word_done(word_done), .busy(busy));

   uart_tx_word_streamer #(.DATA_W(32), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_l (
      .clk(clk), .reset(reset), .wr_en(wr_en_l), .wr_data(wr_data_l),
      .wr_full(wr_full_l), .overflow(overflow_l), .fifo_count(fifo_count_l),
      .byte_data(byte_data_l), .byte_valid(byte_valid_l), .byte_ready(byte_ready_l),
      .word_done(word_done_l), .busy(busy_l));

   // Inputs only change at posedge+1, so a valid&&ready seen here is the
   // transfer that the next rising edge performs.
   always @(negedge clk) begin
      if (!reset) begin
         if (byte_valid && byte_ready)     got.push_back(byte_data);
         if (byte_valid_l && byte_ready_l) got_l.push_back(byte_data_l);
         if (word_done)   done_cnt++;
         if (word_done_l) done_cnt_l++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_word(input logic [31:0] w, input bit msb);
      for (int k = 0; k < 4; k++)
         exp_q.push_back(msb ? w[31-8*k -: 8] : w[8*k +: 8]);
      if (NL != 0) exp_q.push_back(8'h0A);
   endtask

   task automatic chk_bytes(input string tag, input logic [7:0] g[$], input logic [7:0] e[$]);
      chk({tag, "_len"}, 64'(g.size()), 64'(e.size()));
      for (int i = 0; i < e.size() && i < g.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), 64'(g[i]), 64'(e[i]));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || busy_l) && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_idle_timeout"}, 64'(busy || busy_l), 64'(0));
      tick();
   endtask

   initial begin
      logic [31:0] words [5];
      int n;
      words = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F001, 32'h12345678};

      // Reset state
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_valid", 64'(byte_valid), 64'(0));
      chk("rst_data", 64'(byte_data), 64'(0));
      chk("rst_full", 64'(wr_full), 64'(0));
      chk("rst_ovf", 64'(overflow), 64'(0));
      chk("rst_count", 64'(fifo_count), 64'(0));
      chk("rst_done", 64'(word_done), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));

      // 1: single word MSB first, latency
      byte_ready = 1'b1;
      wr_en = 1'b1; wr_data = 32'hDEADBEEF;
      tick();
      wr_en = 1'b0;
      chk("t1_count_after_wr", 64'(fifo_count), 64'(1));
      chk("t1_valid_after_wr", 64'(byte_valid), 64'(0));
      tick();
      chk("t1_valid_after_pop", 64'(byte_valid), 64'(1));
      chk("t1_count_after_pop", 64'(fifo_count), 64'(0));
      chk("t1_first_byte", 64'(byte_data), 64'hDE);
      wait_idle("t1");
      exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      if (NL != 0) exp_q.push_back(8'h0A);
      chk_bytes("t1", got, exp_q);
      chk("t1_done_cnt", 64'(done_cnt), 64'(1));
      chk("t1_busy", 64'(busy), 64'(0));

      // 2: LSB-first instance
      byte_ready_l = 1'b1;
      wr_en_l = 1'b1; wr_data_l = 32'h11223344;
      tick();
      wr_en_l = 1'b0;
      wait_idle("t2");
      exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
      if (NL != 0) exp_q.push_back(8'h0A);
      chk_bytes("t2", got_l, exp_q);
      chk("t2_done_cnt", 64'(done_cnt_l), 64'(1));

      // 3: back-pressure for 5 cycles mid-word
      got.delete(); done_cnt = 0;
      byte_ready = 1'b0;
      wr_en = 1'b1; wr_data = 32'hCAFEF00D;
      tick();
      wr_en = 1'b0;
      tick();
      chk("t3_first", 64'(byte_data), 64'hCA);
      byte_ready = 1'b1;
      tick();
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_hold%0d", i), 64'(byte_data), 64'hFE);
         chk($sformatf("t3_vhold%0d", i), 64'(byte_valid), 64'(1));
         tick();
      end
      byte_ready = 1'b1;
      wait_idle("t3");
      exp_q.delete();
      add_word(32'hCAFEF00D, 1'b1);
      chk_bytes("t3", got, exp_q);
      chk("t3_done_cnt", 64'(done_cnt), 64'(1));

      // 4: fill, overflow, in-order drain
      got.delete(); done_cnt = 0;
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = words[i];
         tick();
      end
      wr_en = 1'b0;
      chk("t4_full", 64'(wr_full), 64'(1));
      chk("t4_count", 64'(fifo_count), 64'(4));
      chk("t4_ovf_before", 64'(overflow), 64'(0));
      chk("t4_inflight", 64'(byte_data), 64'h10);
      wr_en = 1'b1; wr_data = 32'hBADBAD00;
      tick();
      wr_en = 1'b0;
      chk("t4_ovf_after", 64'(overflow), 64'(1));
      chk("t4_count_after_drop", 64'(fifo_count), 64'(4));
      byte_ready = 1'b1;
      wait_idle("t4");
      exp_q.delete();
      for (int i = 0; i < 5; i++) add_word(words[i], 1'b1);
      chk_bytes("t4", got, exp_q);
      chk("t4_done_cnt", 64'(done_cnt), 64'(5));
      chk("t4_ovf_sticky", 64'(overflow), 64'(1));

      // 5: back-to-back words, no bubble
      got.delete(); done_cnt = 0;
      byte_ready = 1'b0;
      wr_en = 1'b1; wr_data = 32'hA1A2A3A4;
      tick();
      wr_data = 32'hB1B2B3B4;
      tick();
      wr_en = 1'b0;
      byte_ready = 1'b1;
      for (int i = 0; i < 2 * BPW; i++) begin
         chk($sformatf("t5_valid%0d", i), 64'(byte_valid), 64'(1));
         tick();
      end
      chk("t5_valid_end", 64'(byte_valid), 64'(0));
      chk("t5_done_pulse", 64'(word_done), 64'(1));
      tick();
      exp_q.delete();
      add_word(32'hA1A2A3A4, 1'b1);
      add_word(32'hB1B2B3B4, 1'b1);
      chk_bytes("t5", got, exp_q);
      chk("t5_done_cnt", 64'(done_cnt), 64'(2));

      // 6: reset after byte 2 of a word, with a word queued and overflow set
      got.delete(); done_cnt = 0;
      wr_en = 1'b1; wr_data = 32'h01020304;
      tick();
      wr_data = 32'h05060708;
      tick();
      wr_en = 1'b0;
      n = 0;
      while (got.size() < 2 && n < 50) begin
         tick();
         n++;
      end
      chk("t6_wait_timeout", 64'(got.size()), 64'(2));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_valid", 64'(byte_valid), 64'(0));
      chk("t6_count", 64'(fifo_count), 64'(0));
      chk("t6_ovf", 64'(overflow), 64'(0));
      chk("t6_busy", 64'(busy), 64'(0));
      repeat (10) tick();
      chk("t6_no_more_bytes", 64'(got.size()), 64'(2));
      chk("t6_no_done", 64'(done_cnt), 64'(0));
      chk("t6_bytes_b0", 64'(got[0]), 64'h01);
      chk("t6_bytes_b1", 64'(got[1]), 64'h02);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
